hazard_ctrl_sb: RTL
===================

Name: hazard_ctrl_sb

Overview:
Parametrised hazard controller for the 5-stage RISC-V pipeline. It provides:
- E-stage operand forwarding for NSRC source ports.
- Load-use stall detection.
- Taken-branch flush.
- A register scoreboard for a long-latency functional unit (divider) whose results retire out of order through W.

It sits beside the pipeline registers and drives their stall and flush enables, plus the E-stage forwarding muxes.

Parameters:
NSRC, 2, number of source operands per instruction (1..3)
AW, 5, register address width; register file has 2**AW entries, entry 0 hardwired zero
LONG_MAX, 2, maximum long-latency ops in flight (1..7)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
RS_D  in  NSRC*AW  decode-stage source addresses, port i at [i*AW +: AW]
RD_D  in  AW  decode-stage destination
LongD  in  1  instruction in D is a long-latency op
RS_E  in  NSRC*AW  execute-stage source addresses
RD_E  in  AW  execute-stage destination
RegWriteE  in  1  E instruction writes a register
LoadE  in  1  E instruction is a load
PCSrcE  in  1  taken branch or jump resolved in E
LongIssueE  in  1  long op leaves E into the long unit this cycle (destination RD_E)
RD_M  in  AW  memory-stage destination
RegWriteM  in  1  M writes a register
RD_W  in  AW  writeback destination
RegWriteW  in  1  W writes a register (includes long-op retirement)
LongDoneW  in  1  long op retiring in W this cycle, destination RD_W
ForwardE  out  2*NSRC  per-port forward select, port i at [2i +: 2]
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
InFlight  out  3  number of long ops outstanding
StallCnt  out  CNT_W  saturating count of cycles with StallD=1

Behaviour:
Reset
- Asynchronous, active-low.
- While rst=0: scoreboard, InFlight and StallCnt are 0, and all combinational outputs are forced 0.

Forwarding (combinational, per port i)
- 2'b10 when RegWriteM & RD_M!=0 & RD_M==RS_E[i].
- Otherwise 2'b01 when RegWriteW & RD_W!=0 & RD_W==RS_E[i].
- Otherwise 2'b00.
- M has priority over W.

Load-use stall
- lwStall = LoadE & RegWriteE & RD_E!=0 & RD_E==RS_D[i] for any i.

Scoreboard stall
- Scoreboard is pend[2**AW-1:0]; pend[0] is never set.
- sbStall is asserted when any of these holds:
  - some RS_D[i]!=0 with pend[RS_D[i]]=1 and not (LongDoneW & RD_W==RS_D[i]). The register file is write-through, so a same-cycle retirement clears the hazard.
  - LongD & RD_D!=0 & pend[RD_D]=1 (WAW), with the same same-cycle-retire exception.
  - LongD & InFlight==LONG_MAX & !LongDoneW (capacity).

Output equations
- stall = lwStall | sbStall.
- StallF = StallD = stall & !PCSrcE.
- FlushD = PCSrcE.
- FlushE = PCSrcE | stall.
- A taken branch kills D, so it overrides stalls.

Scoreboard update (registered, rising edge)
- Set pend[RD_E] when LongIssueE & RD_E!=0.
- Clear pend[RD_W] when LongDoneW.
- Same register set and cleared in the same cycle: set wins.

InFlight counter
- InFlight += LongIssueE − LongDoneW.
- Simultaneous issue and retire leaves it unchanged.
- LongDoneW with InFlight==0 is a protocol error: the counter holds at 0 and does not wrap.
- LongIssueE with InFlight==LONG_MAX cannot occur because the capacity stall prevents it; if it does, the counter saturates.

StallCnt
- Increments when StallD=1.
- Saturates at all-ones.
- Cleared only by reset.

Latency
- Forward, stall and flush outputs are combinational, with 0-cycle latency.
- Scoreboard and counters take effect on the cycle after the triggering edge.

Reset mid-operation
- Asserting rst clears all pending bits immediately; in-flight long results are discarded by the pipeline.

Test Plan:
- Forward priority: RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, RS_E port0=5, port1=0 -> ForwardE[1:0]=10, ForwardE[3:2]=00. Then RegWriteM=0 -> port0 gives 01.
- Load-use: LoadE=1, RegWriteE=1, RD_E=7, RS_D port1=7 -> StallF=StallD=FlushE=1 and FlushD=0. StallCnt increments by 1 per cycle held.
- Branch overrides stall: same load-use condition with PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1. StallCnt does not increment.
- Scoreboard RAW:
  - Pulse LongIssueE with RD_E=9 -> InFlight=1, pend[9]=1.
  - RS_D port0=9 -> StallD=1 every cycle.
  - Cycle with LongDoneW=1, RD_W=9 -> StallD=0 that cycle; InFlight=0 next cycle.
- Capacity and WAW:
  - Issue two long ops, to x3 and x4 -> InFlight=2.
  - LongD=1, RD_D=6 -> StallD=1.
  - Retire x3 -> stall drops that cycle.
  - LongD=1, RD_D=4 -> WAW stall until x4 retires.
- Reset mid-op: pend[9]=1, InFlight=2, StallCnt=5, then rst=0 asynchronously between edges -> all outputs 0 immediately. After release, RS_D=9 produces no stall.

Source files
------------

// File: rtl/hazard_ctrl_sb.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_sb
//
// Hazard controller for a 5-stage RISC-V pipeline:
//   - E-stage operand forwarding (M has priority over W) for NSRC source ports
//   - load-use stall detection
//   - taken-branch flush (overrides any stall)
//   - register scoreboard for a long-latency unit whose results retire
//     out of order through W
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   RS_D, RD_D, LongD decode-stage sources / destination / long-op flag
//   RS_E, RD_E        execute-stage sources / destination
//   RegWriteE, LoadE  E writes a register / E is a load
//   PCSrcE            taken branch or jump resolved in E
//   LongIssueE        long op leaves E this cycle (destination RD_E)
//   RD_M, RegWriteM   memory-stage destination / write enable
//   RD_W, RegWriteW   writeback destination / write enable
//   LongDoneW         long op retires in W this cycle (destination RD_W)
//   ForwardE          per-port forward select: 10 = from M, 01 = from W
//   StallF, StallD    hold PC / hold IF/ID
//   FlushD, FlushE    clear IF/ID / clear ID/EX
//   InFlight          number of long ops outstanding
//   StallCnt          saturating count of cycles with StallD=1
// -----------------------------------------------------------------------------
module hazard_ctrl_sb #(
    parameter int NSRC     = 2,
    parameter int AW       = 5,
    parameter int LONG_MAX = 2,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*AW-1:0]   RS_D,
    input  logic [AW-1:0]        RD_D,
    input  logic                 LongD,
    input  logic [NSRC*AW-1:0]   RS_E,
    input  logic [AW-1:0]        RD_E,
    input  logic                 RegWriteE,
    input  logic                 LoadE,
    input  logic                 PCSrcE,
    input  logic                 LongIssueE,
    input  logic [AW-1:0]        RD_M,
    input  logic                 RegWriteM,
    input  logic [AW-1:0]        RD_W,
    input  logic                 RegWriteW,
    input  logic                 LongDoneW,
    output logic [2*NSRC-1:0]    ForwardE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [2:0]           InFlight,
    output logic [CNT_W-1:0]     StallCnt
);

    localparam int         NREG       = 2 ** AW;
    localparam logic [2:0] LONG_MAX_C = 3'(LONG_MAX);

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_next;
    logic [2:0]        in_flight;
    logic [CNT_W-1:0]  stall_cnt;
    logic [2*NSRC-1:0] fwd;
    logic              lw_stall;
    logic              sb_stall;
    logic              stall;

    // Forwarding and stall detection.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        fwd      = '0;
        lw_stall = 1'b0;
        sb_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (RegWriteM && RD_M != '0 && RD_M == RS_E[i*AW +: AW])
                fwd[2*i +: 2] = 2'b10;
            else if (RegWriteW && RD_W != '0 && RD_W == RS_E[i*AW +: AW])
                fwd[2*i +: 2] = 2'b01;

            if (LoadE && RegWriteE && RD_E != '0 && RD_E == RS_D[i*AW +: AW])
                lw_stall = 1'b1;

            // Write-through register file: a same-cycle retirement of the
            // pending register already resolves the RAW hazard.
            if (RS_D[i*AW +: AW] != '0 && pend[RS_D[i*AW +: AW]] &&
                !(LongDoneW && RD_W == RS_D[i*AW +: AW]))
                sb_stall = 1'b1;
        end

        // WAW against an outstanding long op, same retirement exception.
        if (LongD && RD_D != '0 && pend[RD_D] && !(LongDoneW && RD_W == RD_D))
            sb_stall = 1'b1;

        // Long unit full, unless a slot frees up this very cycle.
        if (LongD && in_flight == LONG_MAX_C && !LongDoneW)
            sb_stall = 1'b1;

        stall = lw_stall | sb_stall;
    end

    // Next scoreboard: clear on retirement first so a same-register issue
    // in the same cycle wins.
    always_comb begin
        pend_next = pend;
        if (LongDoneW)
            pend_next[RD_W] = 1'b0;
        if (LongIssueE && RD_E != '0)
            pend_next[RD_E] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Combinational outputs are forced low while reset is held. A taken
    // branch kills the instruction in D, so it overrides any stall.
    assign ForwardE = rst ? fwd : '0;
    assign StallF   = rst & stall & ~PCSrcE;
    assign StallD   = rst & stall & ~PCSrcE;
    assign FlushD   = rst & PCSrcE;
    assign FlushE   = rst & (PCSrcE | stall);
    assign InFlight = in_flight;
    assign StallCnt = stall_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the scoreboard is a flop array, not a RAM, so it is cleared by
    // the asynchronous reset; pending results are discarded by the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= '0;
            in_flight <= '0;
            stall_cnt <= '0;
        end else begin
            pend <= pend_next;

            if (LongIssueE && !LongDoneW) begin
                if (in_flight != LONG_MAX_C)
                    in_flight <= in_flight + 3'd1;
            end else if (LongDoneW && !LongIssueE) begin
                // A retirement with nothing outstanding is a protocol error;
                // hold at zero rather than wrap.
                if (in_flight != 3'd0)
                    in_flight <= in_flight - 3'd1;
            end

            if (StallD && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
